vslide_seq: RTL and testbench

//  Issue sequencer directly upstream of the vector slide unit, for vslide1up and vslide1down.
//  - Accepts one slide command.
//  - Reads source register vs2 from the VRF as ascending 64-bit beats.
//  - Drives the slide unit's input bus with back-to-back beats, start/end flags, byte enables and destination addresses.
//  - The slide unit has no backpressure and carries a remainder between consecutive beats, so every beat must arrive on consecutive cycles.

---
 rtl/vslide_seq.sv | 190 +++++++++++++++++++
 tb/tb_vslide_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vslide_seq.sv
// rtl/vslide_seq.sv - issue sequencer feeding vs2 beats to the vector slide unit
//
// Accepts one vslide1up/vslide1down command, reads vs2 from the VRF one beat
// per cycle and presents the beats to the slide unit on consecutive cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready = idle)
//   cmd_opSel, cmd_insert     slide direction, insert flag
//   cmd_sew, cmd_vl           element width code, element count
//   cmd_src_addr/dst_addr     vs2 / vd base beat addresses
//   cmd_scalar                scalar operand, SEW-aligned in low bits
//   rd_req_valid/addr         VRF read request
//   rd_resp_data              VRF data, READ_LAT cycles after the request
//   sl_*                      slide unit input bus
//   busy                      command in flight
//   done                      one-cycle completion pulse
module vslide_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int SEW_WIDTH  = 2,
    parameter int VL_WIDTH   = 12,
    parameter int READ_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_opSel,
    input  logic                    cmd_insert,
    input  logic [SEW_WIDTH-1:0]    cmd_sew,
    input  logic [VL_WIDTH-1:0]     cmd_vl,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_scalar,
    output logic                    rd_req_valid,
    output logic [ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [DATA_WIDTH-1:0]   rd_resp_data,
    output logic                    sl_valid,
    output logic [DATA_WIDTH-1:0]   sl_vec0,
    output logic [DATA_WIDTH-1:0]   sl_vec1,
    output logic [SEW_WIDTH-1:0]    sl_sew,
    output logic                    sl_start,
    output logic                    sl_end,
    output logic                    sl_opSel,
    output logic                    sl_insert,
    output logic [ADDR_WIDTH-1:0]   sl_addr,
    output logic [DATA_WIDTH/8-1:0] sl_be,
    output logic                    busy,
    output logic                    done
);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int BL  = $clog2(BW);
    localparam int BYW = VL_WIDTH + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic                  op_q, ins_q;
    logic [SEW_WIDTH-1:0]  sew_q;
    logic [DATA_WIDTH-1:0] scalar_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [VL_WIDTH-1:0]   nbeats_q, idx_q;
    logic [BW-1:0]         last_be_q;
    logic                  done_empty_q;

    // Metadata pipe: travels alongside the VRF read so it lines up with rd_resp_data.
    logic                  p_v     [READ_LAT];
    logic                  p_start [READ_LAT];
    logic                  p_end   [READ_LAT];
    logic [ADDR_WIDTH-1:0] p_addr  [READ_LAT];
    logic [BW-1:0]         p_be    [READ_LAT];

    logic [BYW-1:0]  bytes_c;
    logic [VL_WIDTH-1:0] nbeats_c;
    logic [BL-1:0]   rem_c;
    logic [BW-1:0]   one_hot_c, last_be_c;
    logic            accept, issuing, is_last;

    always_comb begin
        bytes_c   = BYW'(cmd_vl) << cmd_sew;
        nbeats_c  = VL_WIDTH'((bytes_c + BYW'(BW - 1)) >> BL);
        rem_c     = bytes_c[BL-1:0];
        one_hot_c = BW'(1) << rem_c;
        last_be_c = (rem_c == '0) ? '1 : (one_hot_c - BW'(1));
    end

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = ~cmd_ready;
    assign accept       = cmd_valid & cmd_ready;
    assign issuing      = (state == S_ISSUE);
    assign is_last      = (idx_q == nbeats_q - VL_WIDTH'(1));
    assign rd_req_valid = issuing;
    assign rd_req_addr  = issuing ? (src_q + ADDR_WIDTH'(idx_q)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= 1'b0;
            ins_q        <= 1'b0;
            sew_q        <= '0;
            scalar_q     <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            nbeats_q     <= '0;
            idx_q        <= '0;
            last_be_q    <= '0;
            done_empty_q <= 1'b0;
        end else begin
            done_empty_q <= accept && (nbeats_c == '0);
            case (state)
                S_IDLE: begin
                    if (accept && nbeats_c != '0) begin
                        op_q      <= cmd_opSel;
                        ins_q     <= cmd_insert;
                        sew_q     <= cmd_sew;
                        scalar_q  <= cmd_scalar;
                        src_q     <= cmd_src_addr;
                        dst_q     <= cmd_dst_addr;
                        nbeats_q  <= nbeats_c;
                        last_be_q <= last_be_c;
                        idx_q     <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    idx_q <= idx_q + VL_WIDTH'(1);
                    if (is_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // End beat is in the output register now; idle from next cycle.
                    if (sl_valid && sl_end) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                p_v[i]     <= 1'b0;
                p_start[i] <= 1'b0;
                p_end[i]   <= 1'b0;
                p_addr[i]  <= '0;
                p_be[i]    <= '0;
            end
        end else begin
            p_v[0]     <= issuing;
            p_start[0] <= issuing && (idx_q == '0);
            p_end[0]   <= issuing && is_last;
            p_addr[0]  <= dst_q + ADDR_WIDTH'(idx_q);
            p_be[0]    <= is_last ? last_be_q : '1;
            for (int i = 1; i < READ_LAT; i++) begin
                p_v[i]     <= p_v[i-1];
                p_start[i] <= p_start[i-1];
                p_end[i]   <= p_end[i-1];
                p_addr[i]  <= p_addr[i-1];
                p_be[i]    <= p_be[i-1];
            end
        end
    end

    // Output register: metadata leaves the pipe on the same edge the read data is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            sl_valid <= 1'b0;
            sl_start <= 1'b0;
            sl_end   <= 1'b0;
            sl_addr  <= '0;
            sl_be    <= '0;
            sl_vec0  <= '0;
        end else begin
            sl_valid <= p_v[READ_LAT-1];
            sl_start <= p_v[READ_LAT-1] & p_start[READ_LAT-1];
            sl_end   <= p_v[READ_LAT-1] & p_end[READ_LAT-1];
            sl_addr  <= p_v[READ_LAT-1] ? p_addr[READ_LAT-1] : '0;
            sl_be    <= p_v[READ_LAT-1] ? p_be[READ_LAT-1] : '0;
            sl_vec0  <= p_v[READ_LAT-1] ? rd_resp_data : '0;
        end
    end

    assign sl_vec1   = sl_valid ? scalar_q : '0;
    assign sl_sew    = sl_valid ? sew_q : '0;
    assign sl_opSel  = sl_valid & op_q;
    assign sl_insert = sl_valid & ins_q;
    assign done      = done_empty_q | (sl_valid & sl_end);
endmodule

// File: tb/tb_vslide_seq.sv
// tb/tb_vslide_seq.sv - randomized self-checking bench for vslide_seq
module tb_vslide_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic        cmd_opSel = 1'b0, cmd_insert = 1'b0;
    logic [1:0]  cmd_sew = '0;
    logic [11:0] cmd_vl = '0;
    logic [31:0] cmd_src_addr = '0, cmd_dst_addr = '0;
    logic [63:0] cmd_scalar = '0;
    logic        rd_req_valid;
    logic [31:0] rd_req_addr;
    logic [63:0] rd_resp_data;
    logic        sl_valid, sl_start, sl_end, sl_opSel, sl_insert, busy, done;
    logic [63:0] sl_vec0, sl_vec1;
    logic [1:0]  sl_sew;
    logic [31:0] sl_addr;
    logic [7:0]  sl_be;

    vslide_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opSel(cmd_opSel), .cmd_insert(cmd_insert), .cmd_sew(cmd_sew),
        .cmd_vl(cmd_vl), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
        .cmd_scalar(cmd_scalar), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_resp_data(rd_resp_data), .sl_valid(sl_valid), .sl_vec0(sl_vec0),
        .sl_vec1(sl_vec1), .sl_sew(sl_sew), .sl_start(sl_start), .sl_end(sl_end),
        .sl_opSel(sl_opSel), .sl_insert(sl_insert), .sl_addr(sl_addr), .sl_be(sl_be),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] vrf(input logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, a};
    endfunction

    // VRF: data for a request appears exactly two cycles later.
    logic [31:0] rq1 = '0, rq2 = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rq1 <= rd_req_addr;
        rq2 <= rq1;
    end
    assign rd_resp_data = vrf(rq2);

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  be;
        logic        st, en;
        logic [63:0] v0, v1;
        logic [1:0]  sew;
        logic        op, ins;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    int          rd_cyc[$];
    bit          empty_pend = 1'b0;

    // Reference model: expands each accepted command into its reads and beats.
    task automatic model_accept();
        int bytes, nb;
        beat_t b;
        bytes = int'(cmd_vl) * (1 << cmd_sew);
        nb = (bytes + 7) / 8;
        if (nb == 0) empty_pend = 1'b1;
        for (int i = 0; i < nb; i++) begin
            exp_rd.push_back(cmd_src_addr + 32'(i));
            b.addr = cmd_dst_addr + 32'(i);
            b.st   = (i == 0);
            b.en   = (i == nb - 1);
            b.be   = (b.en && (bytes % 8) != 0) ? 8'((1 << (bytes % 8)) - 1) : 8'hFF;
            b.v0   = vrf(cmd_src_addr + 32'(i));
            b.v1   = cmd_scalar;
            b.sew  = cmd_sew;
            b.op   = cmd_opSel;
            b.ins  = cmd_insert;
            exp_beats.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_ready, exp_done;
            beat_t b;
            exp_ready = (exp_beats.size() == 0);
            exp_done  = empty_pend;
            empty_pend = 1'b0;
            check_eq("cmd_ready", cmd_ready, exp_ready);
            check_eq("busy", busy, !exp_ready);
            if (rd_req_valid) begin
                if (exp_rd.size() == 0) check_eq("unexpected_rd", 1, 0);
                else check_eq("rd_addr", rd_req_addr, exp_rd.pop_front());
                rd_cyc.push_back(cyc);
            end
            if (sl_valid) begin
                if (exp_beats.size() == 0) check_eq("unexpected_sl", 1, 0);
                else begin
                    b = exp_beats.pop_front();
                    check_eq("sl_addr", sl_addr, b.addr);
                    check_eq("sl_be", sl_be, b.be);
                    check_eq("sl_start", sl_start, b.st);
                    check_eq("sl_end", sl_end, b.en);
                    check_eq("sl_vec0", sl_vec0, b.v0);
                    check_eq("sl_vec1", sl_vec1, b.v1);
                    check_eq("sl_sew", sl_sew, b.sew);
                    check_eq("sl_opSel", sl_opSel, b.op);
                    check_eq("sl_insert", sl_insert, b.ins);
                    if (rd_cyc.size() != 0) check_eq("latency", cyc - rd_cyc.pop_front(), 3);
                    exp_done = exp_done | b.en;
                end
            end else begin
                check_eq("idle_vec1", sl_vec1, 0);
            end
            check_eq("done", done, exp_done);
            if (!rst && cmd_valid && exp_ready) model_accept();
            if (rst) begin
                exp_beats.delete();
                exp_rd.delete();
                rd_cyc.delete();
                empty_pend = 1'b0;
            end
        end
    end

    task automatic send(input logic op, input logic ins, input logic [1:0] sew, input logic [11:0] vl,
                        input logic [31:0] src, input logic [31:0] dst, input logic [63:0] sc);
        int n;
        cmd_opSel = op; cmd_insert = ins; cmd_sew = sew; cmd_vl = vl;
        cmd_src_addr = src; cmd_dst_addr = dst; cmd_scalar = sc;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 1000);
        if (n >= 1000) check_eq("send_timeout", 1, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_sl_valid", sl_valid, 0);
        check_eq("rst_rd_req", rd_req_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sl_be", sl_be, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        send(0, 0, 2'd0, 12'd16, 32'h10, 32'h20, 64'h11);
        idle(8);
        send(1, 1, 2'd2, 12'd3, 32'h100, 32'h200, 64'hDEAD_BEEF);
        idle(8);
        send(0, 0, 2'd1, 12'd0, 32'h5, 32'h6, 64'h1);
        idle(4);
        send(1, 0, 2'd3, 12'd1, 32'h40, 32'h80, 64'h0123_4567_89AB_CDEF);
        idle(6);
        // Address wrap across 2^32.
        send(0, 1, 2'd0, 12'd20, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'h7);
        // Back-to-back with cmd_valid held high.
        send(1, 0, 2'd1, 12'd5, 32'h300, 32'h400, 64'hAA);
        send(0, 1, 2'd0, 12'd9, 32'h500, 32'h600, 64'hBB);
        send(1, 1, 2'd0, 12'd0, 32'h0, 32'h0, 64'h0);
        send(0, 0, 2'd3, 12'd2, 32'h700, 32'h800, 64'hCC);
        idle(8);

        // Reset in the middle of an 8-beat command.
        send(0, 0, 2'd0, 12'd64, 32'h1000, 32'h2000, 64'h55);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_sl_valid", sl_valid, 0);
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("post_rst_rd_req", rd_req_valid, 0);
        idle(8);

        for (int k = 0; k < 40; k++) begin
            send($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 40)),
                 $urandom, $urandom, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 6));
        end

        n = 0;
        while ((exp_beats.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_beats", exp_beats.size(), 0);
        check_eq("drain_reads", exp_rd.size(), 0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
